// File: rtl/shift_sequencer_if.sv
// Request/response bundle between the execute stage and the multi-cycle shift unit.
interface shift_sequencer_if;
  logic        start;
  logic [1:0]  op;
  logic [31:0] a;
  logic [31:0] b;
  logic        flush;
  logic        ready;
  logic        busy;
  logic        done;
  logic [31:0] s;
  logic        z;
  logic        v;
  logic        n;

  modport master (
    output start, op, a, b, flush,
    input  ready, busy, done, s, z, v, n
  );

  modport slave (
    input  start, op, a, b, flush,
    output ready, busy, done, s, z, v, n
  );
endinterface

// File: rtl/shift_sequencer.sv
// Iterative STEP-bit shift unit (SLL/SRL/SRA/ROTR) with registered result and Z/V/N flags.
// Optional SHIFT_EARLY_EXIT_EN: finish early once the working value can no longer change.
module shift_sequencer #(
  parameter int STEP = 1
) (
  input logic              clk,
  input logic              reset,
  shift_sequencer_if.slave sh_io
);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  localparam logic [1:0] OP_SLL  = 2'b00;
  localparam logic [1:0] OP_SRL  = 2'b01;
  localparam logic [1:0] OP_SRA  = 2'b10;
  localparam logic [1:0] OP_ROTR = 2'b11;

  localparam logic [4:0] STEP_AMT = 5'(STEP);

  if (STEP != 1 && STEP != 2 && STEP != 4 && STEP != 8) begin : g_bad_step
    $error("shift_sequencer: STEP must be 1, 2, 4 or 8");
  end

  logic [1:0]  state_q, state_d;
  logic [1:0]  op_q, op_d;
  logic [31:0] work_q, work_d;
  logic [4:0]  rem_q, rem_d;
  logic        fill_q, fill_d;
  logic [31:0] s_q, s_d;
  logic        z_q, z_d;
  logic        n_q, n_d;

  logic [4:0]  k;
  logic [4:0]  rem_next;
  logic [63:0] ext;
  logic [31:0] shifted;
  logic        unused_a_hi;

  assign unused_a_hi = ^sh_io.a[31:5];

  // One iteration of the narrow shifter; k is zero once the amount is consumed.
  always_comb begin
    k        = (rem_q < STEP_AMT) ? rem_q : STEP_AMT;
    rem_next = rem_q - k;
    case (op_q)
      OP_SLL:  ext = {32'b0, work_q << k};
      OP_SRL:  ext = {32'b0, work_q >> k};
      OP_SRA:  ext = {{32{fill_q}}, work_q} >> k;
      default: ext = {work_q, work_q} >> k;
    endcase
    shifted = ext[31:0];
  end

`ifdef SHIFT_EARLY_EXIT_EN
  logic saturated;
  assign saturated = (op_q != OP_ROTR) &&
                     ((op_q == OP_SRA) ? (work_q == {32{fill_q}}) : (work_q == '0));
`endif

  always_comb begin
    // NOTE: every signal gets a default here so no path leaves one unassigned (no latches).
    state_d = state_q;
    op_d    = op_q;
    work_d  = work_q;
    rem_d   = rem_q;
    fill_d  = fill_q;
    s_d     = s_q;
    z_d     = z_q;
    n_d     = n_q;
    if (sh_io.flush) begin
      state_d = ST_IDLE;
    end else begin
      case (state_q)
        ST_IDLE, ST_DONE: begin
          if (sh_io.start) begin
            op_d    = sh_io.op;
            work_d  = sh_io.b;
            rem_d   = sh_io.a[4:0];
            fill_d  = sh_io.b[31];
            state_d = ST_RUN;
          end else begin
            state_d = ST_IDLE;
          end
        end
        ST_RUN: begin
          work_d = shifted;
          rem_d  = rem_next;
          if (rem_next == '0) begin
            s_d     = shifted;
            z_d     = (shifted == '0);
            n_d     = shifted[31];
            state_d = ST_DONE;
          end
`ifdef SHIFT_EARLY_EXIT_EN
          else if (saturated) begin
            work_d = work_q;
            rem_d  = '0;
          end
`endif
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    // NOTE: non-blocking so every register samples pre-edge values regardless of order.
    if (reset) begin
      state_q <= ST_IDLE;
      op_q    <= OP_SLL;
      work_q  <= '0;
      rem_q   <= '0;
      fill_q  <= 1'b0;
      s_q     <= '0;
      z_q     <= 1'b0;
      n_q     <= 1'b0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      work_q  <= work_d;
      rem_q   <= rem_d;
      fill_q  <= fill_d;
      s_q     <= s_d;
      z_q     <= z_d;
      n_q     <= n_d;
    end
  end

  assign sh_io.ready = (state_q == ST_IDLE) || (state_q == ST_DONE);
  assign sh_io.busy  = (state_q == ST_RUN);
  assign sh_io.done  = (state_q == ST_DONE);
  assign sh_io.s     = s_q;
  assign sh_io.z     = z_q;
  assign sh_io.v     = 1'b0;
  assign sh_io.n     = n_q;

endmodule

// File: tb/tb_shift_sequencer.sv
// Bench for shift_sequencer: STEP=1 and STEP=4 instances driven in lockstep and compared
// every cycle against a latency/result model; honours SHIFT_EARLY_EXIT_EN if defined.
module tb_shift_sequencer;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [1:0]  op;
  logic [31:0] a;
  logic [31:0] b;
  logic        flush;
  logic        chk_en = 1'b0;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  shift_sequencer_if bus1 ();
  shift_sequencer_if bus4 ();

  assign bus1.start = start;
  assign bus1.op    = op;
  assign bus1.a     = a;
  assign bus1.b     = b;
  assign bus1.flush = flush;
  assign bus4.start = start;
  assign bus4.op    = op;
  assign bus4.a     = a;
  assign bus4.b     = b;
  assign bus4.flush = flush;

  shift_sequencer #(.STEP(1)) u_dut1 (.clk(clk), .reset(reset), .sh_io(bus1));
  shift_sequencer #(.STEP(4)) u_dut4 (.clk(clk), .reset(reset), .sh_io(bus4));

  logic        d_ready [2];
  logic        d_busy  [2];
  logic        d_done  [2];
  logic [31:0] d_s     [2];
  logic        d_z     [2];
  logic        d_v     [2];
  logic        d_n     [2];

  assign d_ready[0] = bus1.ready;  assign d_ready[1] = bus4.ready;
  assign d_busy[0]  = bus1.busy;   assign d_busy[1]  = bus4.busy;
  assign d_done[0]  = bus1.done;   assign d_done[1]  = bus4.done;
  assign d_s[0]     = bus1.s;      assign d_s[1]     = bus4.s;
  assign d_z[0]     = bus1.z;      assign d_z[1]     = bus4.z;
  assign d_v[0]     = bus1.v;      assign d_v[1]     = bus4.v;
  assign d_n[0]     = bus1.n;      assign d_n[1]     = bus4.n;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  function automatic int step_of(input int d);
    return (d == 0) ? 1 : 4;
  endfunction

  function automatic logic [31:0] ref_shift(input logic [1:0] o, input int amt,
                                            input logic [31:0] v);
    case (o)
      2'b00:   return v << amt;
      2'b01:   return v >> amt;
      2'b10:   return 32'($signed(v) >>> amt);
      default: return (amt == 0) ? v : ((v >> amt) | (v << (32 - amt)));
    endcase
  endfunction

  // Edges from the start edge to the edge that raises done.
  function automatic int model_lat(input int stp, input logic [1:0] o, input int amt,
                                   input logic [31:0] v);
    int nom;
    nom = (amt == 0) ? 1 : (amt + stp - 1) / stp;
`ifdef SHIFT_EARLY_EXIT_EN
    if (o != 2'b11) begin
      for (int j = 0; j < nom; j++) begin
        logic [31:0] w;
        logic        sat;
        w   = ref_shift(o, (j * stp < amt) ? j * stp : amt, v);
        sat = (o == 2'b10) ? (w == {32{v[31]}}) : (w == 32'd0);
        if (sat) return (j + 2 < nom) ? j + 2 : nom;
      end
    end
`endif
    return nom;
  endfunction

  int          m_cnt  [2];
  logic        m_done [2];
  logic [31:0] m_s    [2];
  logic        m_z    [2];
  logic [31:0] m_pend [2];

  always @(posedge clk) begin
    for (int d = 0; d < 2; d++) begin
      int          cnt;
      logic        dn;
      logic [31:0] sv;
      logic        zv;
      logic [31:0] pv;
      cnt = m_cnt[d]; dn = 1'b0; sv = m_s[d]; zv = m_z[d]; pv = m_pend[d];
      if (reset) begin
        cnt = 0; sv = '0; zv = 1'b0;
      end else if (flush) begin
        cnt = 0;
      end else if (cnt != 0) begin
        cnt--;
        if (cnt == 0) begin
          dn = 1'b1; sv = pv; zv = (pv == 32'd0);
        end
      end else if (start) begin
        pv  = ref_shift(op, int'(a[4:0]), b);
        cnt = model_lat(step_of(d), op, int'(a[4:0]), b);
      end
      m_cnt[d] <= cnt; m_done[d] <= dn; m_s[d] <= sv; m_z[d] <= zv; m_pend[d] <= pv;
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      for (int d = 0; d < 2; d++) begin
        check($sformatf("dut%0d ready", step_of(d)), 32'(d_ready[d]), 32'(m_cnt[d] == 0));
        check($sformatf("dut%0d busy", step_of(d)),  32'(d_busy[d]),  32'(m_cnt[d] != 0));
        check($sformatf("dut%0d done", step_of(d)),  32'(d_done[d]),  32'(m_done[d]));
        check($sformatf("dut%0d S", step_of(d)),     d_s[d],          m_s[d]);
        check($sformatf("dut%0d Z", step_of(d)),     32'(d_z[d]),     32'(m_z[d]));
        check($sformatf("dut%0d N", step_of(d)),     32'(d_n[d]),     32'(m_s[d][31]));
        check($sformatf("dut%0d V", step_of(d)),     32'(d_v[d]),     32'd0);
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic step_clk();
    @(posedge clk);
    #1;
  endtask

  task automatic run_op(input string name, input logic [1:0] o, input logic [31:0] av,
                        input logic [31:0] bv, input int lat1, input int lat4,
                        input logic [31:0] exp_s);
    int got1;
    int got4;
    got1 = 0; got4 = 0;
    start = 1'b1; op = o; a = av; b = bv;
    step_clk();
    start = 1'b0;
    a = $urandom; b = $urandom;
    for (int e = 1; e <= 40; e++) begin
      step_clk();
      if (d_done[0] && got1 == 0) got1 = e;
      if (d_done[1] && got4 == 0) got4 = e;
    end
    check({name, " latency step1"}, 32'(got1), 32'(lat1));
    check({name, " latency step4"}, 32'(got4), 32'(lat4));
    check({name, " S step1"}, d_s[0], exp_s);
    check({name, " S step4"}, d_s[1], exp_s);
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; flush = 1'b0; op = 2'b00; a = '0; b = '0;
    step_clk();
    chk_en = 1'b1;
    step_clk();
    reset = 1'b0;
    step_clk();
    check("reset ready", 32'(d_ready[0]), 32'd1);
    check("reset busy",  32'(d_busy[0]),  32'd0);
    check("reset S",     d_s[0],          32'd0);
    check("reset Z",     32'(d_z[0]),     32'd0);

    run_op("sra", 2'b10, 32'd4, 32'h8000_0000, 4, 1, 32'hF800_0000);
    check("sra N", 32'(d_n[0]), 32'd1);
    check("sra Z", 32'(d_z[0]), 32'd0);
    check("sra V", 32'(d_v[0]), 32'd0);
    run_op("srl", 2'b01, 32'd28, 32'hF000_0000, 28, 7, 32'h0000_000F);
    check("srl N", 32'(d_n[1]), 32'd0);
    run_op("sll0", 2'b00, 32'hFFFF_FFE0, 32'h1234_5678, 1, 1, 32'h1234_5678);
    run_op("rotr", 2'b11, 32'd1, 32'h0000_0001, 1, 1, 32'h8000_0000);

    // Flush sampled at the 10th edge after the start edge; start mid-run is ignored.
    start = 1'b1; op = 2'b00; a = 32'd31; b = 32'h1;
    step_clk();
    start = 1'b0;
    for (int e = 1; e <= 9; e++) begin
      start = (e == 5);
      step_clk();
    end
    start = 1'b0;
    check("flush pre busy", 32'(d_busy[0]), 32'd1);
    flush = 1'b1;
    step_clk();
    flush = 1'b0;
    check("flush ready", 32'(d_ready[0]), 32'd1);
    check("flush busy",  32'(d_busy[0]),  32'd0);
    check("flush S kept", d_s[0], 32'h8000_0000);
    begin
      int dones;
      dones = 0;
      for (int e = 0; e < 30; e++) begin
        step_clk();
        if (d_done[0]) dones++;
      end
      check("flush no done", 32'(dones), 32'd0);
    end

`ifdef SHIFT_EARLY_EXIT_EN
    run_op("sll zero", 2'b00, 32'd31, 32'h0, 2, 2, 32'h0);
`else
    run_op("sll zero", 2'b00, 32'd31, 32'h0, 31, 8, 32'h0);
`endif
    check("sll zero Z", 32'(d_z[0]), 32'd1);

    // Back-to-back: start held through the DONE cycle.
    start = 1'b1; op = 2'b00; a = 32'd0; b = 32'h11;
    step_clk();
    step_clk();
    check("b2b done1", 32'(d_done[0]), 32'd1);
    check("b2b S1", d_s[1], 32'h11);
    b = 32'h22;
    step_clk();
    start = 1'b0;
    check("b2b ready low", 32'(d_ready[0]), 32'd0);
    check("b2b busy", 32'(d_busy[1]), 32'd1);
    step_clk();
    check("b2b done2", 32'(d_done[0]), 32'd1);
    check("b2b S2", d_s[0], 32'h22);
    step_clk();

    // Reset mid-run.
    start = 1'b1; op = 2'b00; a = 32'd31; b = 32'h3;
    step_clk();
    start = 1'b0;
    repeat (3) step_clk();
    reset = 1'b1;
    step_clk();
    reset = 1'b0;
    check("rst ready", 32'(d_ready[0]), 32'd1);
    check("rst busy",  32'(d_busy[0]),  32'd0);
    check("rst done",  32'(d_done[0]),  32'd0);
    check("rst S",     d_s[0],          32'd0);
    check("rst Z",     32'(d_z[0]),     32'd0);
    check("rst N",     32'(d_n[0]),     32'd0);

    // Randomised traffic; the compare process checks every cycle.
    for (int i = 0; i < 3000; i++) begin
      start = ($urandom_range(0, 2) == 0);
      op    = 2'($urandom_range(0, 3));
      a     = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 3)) : $urandom;
      case ($urandom_range(0, 4))
        0:       b = 32'h0;
        1:       b = 32'hFFFF_FFFF;
        2:       b = 32'h8000_0000 | ($urandom & 32'hF);
        default: b = $urandom;
      endcase
      flush = ($urandom_range(0, 49) == 0);
      reset = ($urandom_range(0, 299) == 0);
      step_clk();
    end
    start = 1'b0; flush = 1'b0; reset = 1'b0;
    repeat (40) step_clk();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
